dac_jesd204_fifo: RTL and testbench

Elastic buffer between the transmit DMA stream and the JESD204 DAC core, in the DAC clock domain. Accepts DMA words on an AXI-stream handshake, prefills to a threshold, then serves the core's per-channel `dac_valid` read strobes with `dac_ddata`. Signals underflow on `dac_dunf` and keeps a saturating underflow count for software.

---
 rtl/dac_jesd204_fifo_pkg.sv | 22 ++
 rtl/dac_jesd204_fifo_mem.sv | 39 +++
 rtl/dac_jesd204_fifo.sv | 145 ++++++++++++++
 tb/tb_dac_jesd204_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_jesd204_fifo_pkg.sv
// ----------------------------------------------------------------------------
// dac_jesd204_fifo_pkg : shared constants for the DAC JESD204 elastic buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dac_jesd204_fifo_pkg;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_PREFILL = 2'd1;
  localparam logic [1:0] c_ST_RUN     = 2'd2;
  localparam logic [1:0] c_ST_FLUSH   = 2'd3;

  localparam int c_UNF_CNT_W = 16;

  function automatic int calc_dw(input int num_lanes);
    return num_lanes * 32;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_jesd204_fifo_mem.sv
// ----------------------------------------------------------------------------
// dac_jesd204_fifo_mem : simple dual-port RAM, one write port, registered read
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dac_jesd204_fifo_mem #(
  parameter int DW         = 128,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DW-1:0]         i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DW-1:0]         o_rd_data
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DW-1:0] r_mem [0:c_DEPTH-1];
  logic [DW-1:0] r_rd_data;

  // Read register only loads on a pop so the last word is held between reads.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/dac_jesd204_fifo.sv
// ----------------------------------------------------------------------------
// dac_jesd204_fifo : DMA-to-DAC elastic buffer with prefill and underflow count
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dac_jesd204_fifo
  import dac_jesd204_fifo_pkg::*;
#(
  parameter  int NUM_LANES      = 4,
  parameter  int NUM_CHANNELS   = 2,
  parameter  int ADDR_WIDTH     = 5,
  parameter  int FILL_THRESHOLD = 16,
  localparam int DW             = calc_dw(NUM_LANES)
) (
  input  logic                    dac_clk,
  input  logic                    dac_rstn,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  input  logic [DW-1:0]           s_axis_data,
  input  logic                    s_axis_last,
  input  logic [NUM_CHANNELS-1:0] dac_enable,
  input  logic [NUM_CHANNELS-1:0] dac_valid,
  output logic [DW-1:0]           dac_ddata,
  output logic                    dac_dunf,
  output logic [ADDR_WIDTH:0]     fifo_level,
  output logic [c_UNF_CNT_W-1:0]  underflow_count,
  input  logic                    count_clear
);

  localparam logic [ADDR_WIDTH:0] c_FULL_LVL = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] c_THR      = (ADDR_WIDTH+1)'(FILL_THRESHOLD);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [ADDR_WIDTH:0]    r_wptr;
  logic [ADDR_WIDTH:0]    r_rptr;
  logic [ADDR_WIDTH:0]    w_level;
  logic [ADDR_WIDTH:0]    w_level_nxt;
  logic                   r_ready;
  logic                   r_zero;
  logic                   r_dunf;
  logic [c_UNF_CNT_W-1:0] r_ucnt;
  logic                   w_armed;
  logic                   w_rd_req;
  logic                   w_wr;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_unf;
  logic [DW-1:0]          w_mem_q;

  assign w_armed  = |dac_enable;
  assign w_rd_req = |(dac_valid & dac_enable);
  assign w_wr     = s_axis_valid & r_ready;
  assign w_level  = r_wptr - r_rptr;
  assign w_empty  = (w_level == '0);
  assign w_pop    = (r_state == c_ST_RUN) & w_rd_req & ~w_empty;
  assign w_unf    = (r_state == c_ST_RUN) & w_rd_req & w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_armed) w_state_nxt = c_ST_PREFILL;
      end
      c_ST_PREFILL: begin
        if (!w_armed) begin
          w_state_nxt = c_ST_FLUSH;
        end else if ((w_level >= c_THR) || (w_wr && s_axis_last)) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        if (!w_armed) w_state_nxt = c_ST_FLUSH;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Ready is registered from the next level, so it never stays high into a full cycle.
  always_comb begin
    if (r_state == c_ST_FLUSH) begin
      w_level_nxt = '0;
    end else begin
      w_level_nxt = w_level + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_pop);
    end
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      r_state <= c_ST_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ready <= 1'b0;
      r_zero  <= 1'b1;
      r_dunf  <= 1'b0;
      r_ucnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_FLUSH) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr)  r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
      r_ready <= ((w_state_nxt == c_ST_PREFILL) || (w_state_nxt == c_ST_RUN)) &&
                 (w_level_nxt != c_FULL_LVL);
      r_dunf  <= w_unf;
      // r_zero masks the RAM read register whenever the output must read as zero.
      if ((r_state == c_ST_FLUSH) || (r_state == c_ST_PREFILL) || w_unf) begin
        r_zero <= 1'b1;
      end else if (w_pop) begin
        r_zero <= 1'b0;
      end
      if (count_clear) begin
        r_ucnt <= '0;
      end else if (w_unf && (r_ucnt != '1)) begin
        r_ucnt <= r_ucnt + c_UNF_CNT_W'(1);
      end
    end
  end

  dac_jesd204_fifo_mem #(
    .DW         (DW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk     (dac_clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wr_data (s_axis_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_mem_q)
  );

  assign s_axis_ready    = r_ready;
  assign dac_ddata       = r_zero ? '0 : w_mem_q;
  assign dac_dunf        = r_dunf;
  assign fifo_level      = w_level;
  assign underflow_count = r_ucnt;

endmodule

`default_nettype wire

// File: tb/tb_dac_jesd204_fifo.sv
// ----------------------------------------------------------------------------
// tb_dac_jesd204_fifo : scoreboard bench for the DAC JESD204 elastic buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dac_jesd204_fifo;

  localparam int DW = 128;

  logic          dac_clk = 1'b0;
  logic          dac_rstn = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_last = 1'b0;
  logic [1:0]    dac_enable = 2'b00;
  logic [1:0]    dac_valid = 2'b00;
  logic [DW-1:0] dac_ddata;
  logic          dac_dunf;
  logic [5:0]    fifo_level;
  logic [15:0]   underflow_count;
  logic          count_clear = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int wbase    = 0;
  bit chk_on   = 1'b1;

  dac_jesd204_fifo u_dut (
    .dac_clk         (dac_clk),
    .dac_rstn        (dac_rstn),
    .s_axis_valid    (s_axis_valid),
    .s_axis_ready    (s_axis_ready),
    .s_axis_data     (s_axis_data),
    .s_axis_last     (s_axis_last),
    .dac_enable      (dac_enable),
    .dac_valid       (dac_valid),
    .dac_ddata       (dac_ddata),
    .dac_dunf        (dac_dunf),
    .fifo_level      (fifo_level),
    .underflow_count (underflow_count),
    .count_clear     (count_clear)
  );

  always #5 dac_clk = ~dac_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] mkword(input int i);
    return {32'(i) ^ 32'hA5A5_0000, 32'(i * 3 + 1), ~32'(i), 32'(i)};
  endfunction

  // Reference model: behavioural state plus a queue of accepted words.
  logic [1:0]    m_state = 2'd0;
  logic [1:0]    m_nxt;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] e_ddata = '0;
  logic          e_dunf  = 1'b0;
  logic          e_ready = 1'b0;
  logic [15:0]   e_cnt   = '0;
  bit            m_armed, m_rdreq, m_wr, m_pop, m_unf;
  int            m_lvl;

  initial begin
    forever begin
      @(posedge dac_clk or negedge dac_rstn);
      if (!dac_rstn) begin
        m_state = 2'd0;
        m_q.delete();
        e_ddata = '0;
        e_dunf  = 1'b0;
        e_ready = 1'b0;
        e_cnt   = '0;
      end else begin
        m_armed = |dac_enable;
        m_rdreq = |(dac_valid & dac_enable);
        m_wr    = s_axis_valid && e_ready;
        m_lvl   = m_q.size();
        case (m_state)
          2'd0:    m_nxt = m_armed ? 2'd1 : 2'd0;
          2'd1:    m_nxt = !m_armed ? 2'd3 :
                           ((m_lvl >= 16 || (m_wr && s_axis_last)) ? 2'd2 : 2'd1);
          2'd2:    m_nxt = !m_armed ? 2'd3 : 2'd2;
          default: m_nxt = 2'd0;
        endcase
        m_pop = (m_state == 2'd2) && m_rdreq && (m_lvl != 0);
        m_unf = (m_state == 2'd2) && m_rdreq && (m_lvl == 0);
        if (m_pop) e_ddata = m_q.pop_front();
        else if (m_unf || m_state == 2'd3) e_ddata = '0;
        e_dunf = m_unf;
        if (m_wr) m_q.push_back(s_axis_data);
        if (m_state == 2'd3) m_q.delete();
        if (count_clear) e_cnt = '0;
        else if (m_unf && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        e_ready = (m_nxt == 2'd1 || m_nxt == 2'd2) && (m_q.size() < 32);
        m_state = m_nxt;
      end
    end
  end

  initial begin
    forever begin
      @(negedge dac_clk);
      if (chk_on) begin
        chk("ready", s_axis_ready, e_ready);
        chk("level", fifo_level, m_q.size());
        chk("ddata", dac_ddata, e_ddata);
        chk("dunf", dac_dunf, e_dunf);
        chk("ucount", underflow_count, e_cnt);
      end
    end
  end

  // Offers nw words over ncyc cycles; a word advances when the DUT accepted it.
  task automatic run(input int nw, input int ncyc, input logic [1:0] rv, input bit use_last);
    int   idx = 0;
    logic rdy;
    for (int c = 0; c < ncyc; c++) begin
      dac_valid    = rv;
      s_axis_valid = (idx < nw);
      s_axis_data  = mkword(wbase + idx);
      s_axis_last  = use_last && (idx == nw - 1);
      rdy          = s_axis_ready;
      @(negedge dac_clk);
      if (s_axis_valid && rdy) idx++;
    end
    wbase        = wbase + idx;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic go_idle();
    dac_enable = 2'b00;
    dac_valid  = 2'b00;
    @(negedge dac_clk);
    chk("flush_ready", s_axis_ready, 1'b0);
    @(negedge dac_clk);
    chk("idle_level", fifo_level, 6'd0);
    chk("idle_ready", s_axis_ready, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge dac_clk);
    chk("rst_ready", s_axis_ready, 1'b0);
    chk("rst_ddata", dac_ddata, '0);
    chk("rst_level", fifo_level, 6'd0);
    @(posedge dac_clk);
    #2 dac_rstn = 1'b1;
    @(negedge dac_clk);

    // prefill to threshold, then drain past the last word into underflow
    dac_enable = 2'b11;
    run(20, 60, 2'b11, 1'b0);
    chk("unf_dunf", dac_dunf, 1'b1);
    chk("unf_ddata", dac_ddata, '0);
    go_idle();

    // fill to capacity with reads held off, then drain
    dac_enable = 2'b11;
    run(40, 80, 2'b00, 1'b0);
    chk("full_level", fifo_level, 6'd32);
    chk("full_ready", s_axis_ready, 1'b0);
    run(0, 45, 2'b11, 1'b0);
    go_idle();

    // 10 words with last, disable while in RUN, then fresh short transfer
    dac_enable = 2'b11;
    run(10, 20, 2'b00, 1'b1);
    chk("mid_level", fifo_level, 6'd10);
    go_idle();
    dac_enable = 2'b11;
    run(3, 20, 2'b11, 1'b1);
    chk("short_dunf", dac_dunf, 1'b1);
    go_idle();

    // counter saturation and clear priority
    dac_enable = 2'b11;
    run(1, 10, 2'b11, 1'b1);
    run(0, 65540, 2'b11, 1'b0);
    chk("cnt_sat", underflow_count, 16'hFFFF);
    count_clear = 1'b1;
    @(negedge dac_clk);
    count_clear = 1'b0;
    chk("cnt_clr", underflow_count, 16'h0000);
    run(0, 3, 2'b11, 1'b0);

    // asynchronous reset mid-stream
    run(6, 4, 2'b11, 1'b0);
    @(posedge dac_clk);
    #2 dac_rstn = 1'b0;
    @(negedge dac_clk);
    chk("mrst_ready", s_axis_ready, 1'b0);
    chk("mrst_ddata", dac_ddata, '0);
    chk("mrst_dunf", dac_dunf, 1'b0);
    chk("mrst_level", fifo_level, 6'd0);
    chk("mrst_cnt", underflow_count, 16'h0000);
    @(posedge dac_clk);
    #2 dac_rstn = 1'b1;
    @(negedge dac_clk);
    run(2, 12, 2'b11, 1'b1);
    go_idle();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
